// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words from instruction memory
// and resolves the next PC once the datapath retires the held instruction.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        exec_done,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] signimm,
    input  logic [31:0] jr_target,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        fetch_err
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_STALL
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_nxt;
    logic [31:0]   r_instr;
    logic [31:0]   w_instr_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_err;
    logic          w_err_nxt;
    logic [31:0]   w_pcplus4;
    logic [31:0]   w_br_target;
    logic [31:0]   w_next_pc;
    logic          w_unused;

    assign w_pcplus4   = r_pc + 32'd4;
    assign w_br_target = w_pcplus4 + {signimm[29:0], 2'b00};
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_unused    = ^{jr_target[1:0], signimm[31:30]};

    always_comb begin
        w_next_pc = w_pcplus4;
        if (jr) begin
            w_next_pc = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            w_next_pc = {w_pcplus4[31:28], r_instr[25:0], 2'b00};
        end else if (pcsrc) begin
            w_next_pc = w_br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= PC_INIT;
            r_instr <= 32'h0000_0000;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = S_EXEC;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    // Timeout counts only cycles spent waiting on memory
                    if (w_cnt_inc == LIMIT) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_STALL;
                    end
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    w_pc_nxt    = w_next_pc;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_STALL: begin
                w_err_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_EXEC);
    assign instr       = r_instr;
    assign op          = r_instr[31:26];
    assign funct       = r_instr[5:0];
    assign pc          = r_pc;
    assign pcplus4     = w_pcplus4;
    assign fetch_err   = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetch addresses
// and retiring instructions, a negedge monitor pops and compares them.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        exec_done;
    logic        pcsrc;
    logic        jump;
    logic        jr;
    logic [31:0] signimm;
    logic [31:0] jr_target;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  op;
        logic [5:0]  funct;
    } exec_t;

    logic [31:0] q_fetch[$];
    exec_t       q_exec[$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(16)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .exec_done(exec_done), .pcsrc(pcsrc), .jump(jump), .jr(jr),
        .signimm(signimm), .jr_target(jr_target),
        .instr(instr), .op(op), .funct(funct),
        .instr_valid(instr_valid), .pc(pc), .pcplus4(pcplus4),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (imem_req === 1'b1 && imem_ready === 1'b1) begin
                if (q_fetch.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_unexpected got %h want none", imem_addr);
                end else begin
                    logic [31:0] ea;
                    ea = q_fetch.pop_front();
                    chk("imem_addr", imem_addr, ea);
                end
            end
            if (instr_valid === 1'b1 && exec_done === 1'b1) begin
                if (q_exec.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL exec_unexpected got %h want none", pc);
                end else begin
                    exec_t e;
                    e = q_exec.pop_front();
                    chk("exec_pc", pc, e.pc);
                    chk("exec_instr", instr, e.instr);
                    chk("exec_op", 32'(op), 32'(e.op));
                    chk("exec_funct", 32'(funct), 32'(e.funct));
                    chk("exec_pcplus4", pcplus4, e.pc + 32'd4);
                end
            end
        end
    end

    task automatic fetch(input int dly, input logic [31:0] word,
                         input logic [31:0] exp_addr, input bit nogap);
        int n;
        n = 0;
        if (nogap) chk("nogap_req", 32'(imem_req), 32'd1);
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (imem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL fetch_wait got %0d want 1", imem_req);
            return;
        end
        q_fetch.push_back(exp_addr);
        repeat (dly) tick();
        imem_ready = 1'b1;
        imem_rdata = word;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_0000;
        chk("instr_latch", instr, word);
        chk("instr_valid", 32'(instr_valid), 32'd1);
    endtask

    task automatic exec(input int lat, input logic b, input logic j,
                        input logic r, input logic [31:0] simm,
                        input logic [31:0] jt, input logic [31:0] epc,
                        input logic [31:0] ein, input logic [5:0] eop,
                        input logic [5:0] efn);
        exec_t e;
        e.pc = epc;
        e.instr = ein;
        e.op = eop;
        e.funct = efn;
        q_exec.push_back(e);
        exec_done = 1'b0;
        repeat (lat - 1) tick();
        pcsrc = b;
        jump = j;
        jr = r;
        signimm = simm;
        jr_target = jt;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        pcsrc = 1'b0;
        jump = 1'b0;
        jr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        imem_rdata = 32'hBAD0_0000;
        imem_ready = 1'b0;
        exec_done = 1'b0;
        pcsrc = 1'b0;
        jump = 1'b0;
        jr = 1'b0;
        signimm = 32'h0;
        jr_target = 32'h0;
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        reset = 1'b0;
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        fetch(0, 32'h2008_0005, 32'h0, 1'b1);
        chk("op_addi", 32'(op), 32'h08);
        chk("funct_addi", 32'(funct), 32'h05);
        exec(1, 0, 0, 0, 0, 0, 32'h0, 32'h2008_0005, 6'h08, 6'h05);
        chk("valid_one_cycle", 32'(instr_valid), 32'd0);
        fetch(0, 32'h0000_0000, 32'h4, 1'b1);
        exec(2, 0, 0, 0, 0, 0, 32'h4, 32'h0, 6'h00, 6'h00);
        fetch(0, 32'h0000_0000, 32'h8, 1'b1);
        exec(1, 0, 0, 0, 0, 0, 32'h8, 32'h0, 6'h00, 6'h00);
        fetch(0, 32'h0000_0000, 32'hC, 1'b1);
        exec(1, 0, 0, 0, 0, 0, 32'hC, 32'h0, 6'h00, 6'h00);

        fetch(0, 32'h1000_FFFE, 32'h10, 1'b1);
        exec(1, 1, 0, 0, 32'hFFFF_FFFE, 0, 32'h10, 32'h1000_FFFE, 6'h04, 6'h3E);
        fetch(0, 32'h0000_0000, 32'hC, 1'b1);
        exec(1, 0, 0, 0, 0, 0, 32'hC, 32'h0, 6'h00, 6'h00);
        fetch(0, 32'h1000_0003, 32'h10, 1'b1);
        exec(1, 1, 0, 0, 32'h3, 0, 32'h10, 32'h1000_0003, 6'h04, 6'h03);

        fetch(0, 32'h03E0_0008, 32'h20, 1'b1);
        exec(1, 0, 0, 1, 0, 32'h4000_0000, 32'h20, 32'h03E0_0008, 6'h00, 6'h08);
        fetch(0, 32'h0800_0100, 32'h4000_0000, 1'b1);
        exec(1, 0, 1, 0, 0, 0, 32'h4000_0000, 32'h0800_0100, 6'h02, 6'h00);
        fetch(0, 32'h0C00_0000, 32'h4000_0400, 1'b1);
        exec(1, 1, 1, 1, 32'h5, 32'h0000_1237, 32'h4000_0400,
             32'h0C00_0000, 6'h03, 6'h00);

        fetch(5, 32'h8C09_0004, 32'h0000_1234, 1'b1);
        chk("wait5_err", 32'(fetch_err), 32'd0);
        exec(1, 0, 0, 0, 0, 0, 32'h1234, 32'h8C09_0004, 6'h23, 6'h04);

        chk("to_req", 32'(imem_req), 32'd1);
        chk("to_addr", imem_addr, 32'h0000_1238);
        repeat (15) tick();
        chk("to_err_15", 32'(fetch_err), 32'd0);
        chk("to_req_15", 32'(imem_req), 32'd1);
        tick();
        chk("to_err_16", 32'(fetch_err), 32'd1);
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_valid", 32'(instr_valid), 32'd0);
        imem_ready = 1'b1;
        exec_done = 1'b1;
        repeat (3) tick();
        imem_ready = 1'b0;
        exec_done = 1'b0;
        chk("stall_hold_req", 32'(imem_req), 32'd0);
        chk("stall_hold_err", 32'(fetch_err), 32'd1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_clr_err", 32'(fetch_err), 32'd0);
        tick();
        chk("refetch_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_0000;
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_err", 32'(fetch_err), 32'd0);
        chk("midrst_req", 32'(imem_req), 32'd0);
        reset = 1'b0;

        fetch(0, 32'h2402_0001, 32'h0, 1'b0);
        exec(1, 0, 0, 0, 0, 0, 32'h0, 32'h2402_0001, 6'h09, 6'h01);
        tick();
        chk("q_fetch_empty", 32'(q_fetch.size()), 32'd0);
        chk("q_exec_empty", 32'(q_exec.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
